// File: rtl/scope_pkg.sv
// Shared types and default display constants for the scope capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scope_pkg;

  localparam int SAMPLE_W_DEF  = 12;
  localparam int H_DISPLAY_DEF = 640;
  localparam int V_DISPLAY_DEF = 480;
  localparam int ADDR_W_DEF    = 10;
  localparam int DECIM_W_DEF   = 8;

  // Encodings are visible on the state port, so they are fixed explicitly.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_READY   = 3'd3,
    ST_SWAP    = 3'd4
  } capture_state_t;

endpackage

// File: rtl/scope_capture_sample_ram.sv
// Double-bank sample store: one write port, one registered read port.
// Latency: write visible to reads on the following cycle; read data 1 cycle after address.
// Backpressure: none, both ports accept every cycle.
module sample_ram #(
  parameter int DATA_W = 12,
  parameter int AW     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // Write port; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register is reset so the display output is defined out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/scope_capture_ctrl.sv
// Trigger/capture FSM writing one screen of decimated samples to the back bank, swapping at vblank.
// Latency: trigger sample written on the triggering edge; rd_sample lags h by 1 cycle.
// Backpressure: none; samples arriving outside ARMED/CAPTURE are dropped.
module scope_capture_ctrl
  import scope_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DECIM_W   = DECIM_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_rising,
  input  logic                auto_rearm,
  input  logic                arm,
  input  logic [DECIM_W-1:0]  decim,
  input  logic [9:0]          h,
  input  logic [9:0]          v,
  output logic [SAMPLE_W-1:0] rd_sample,
  output logic                front_bank,
  output logic [2:0]          state,
  output logic [15:0]         frame_count
);

  localparam logic [9:0]        H_LIM     = 10'(H_DISPLAY);
  localparam logic [9:0]        V_TICK    = 10'(V_DISPLAY);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_DISPLAY - 1);

  capture_state_t      cur_st, nxt_st;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DECIM_W-1:0]  dcnt;
  logic [SAMPLE_W-1:0] prev;
  logic                prev_ok;
  logic                tick, live, accept, trig_hit, we, enter_armed;
  logic [ADDR_W-1:0]   rd_addr;

  assign tick    = (h == 10'd0) && (v == V_TICK);
  assign live    = (cur_st == ST_ARMED) || (cur_st == ST_CAPTURE);
  assign accept  = live && sample_valid && (dcnt == '0);
  assign rd_addr = (h < H_LIM) ? ADDR_W'(h) : '0;
  assign state   = cur_st;

  // Level-crossing test against the previous accepted sample.
  always_comb begin
    trig_hit = 1'b0;
    if (trig_rising) trig_hit = (prev < trig_level) && (sample >= trig_level);
    else             trig_hit = (prev > trig_level) && (sample <= trig_level);
  end

  // Next-state decode plus the write strobe and the arming event.
  always_comb begin
    nxt_st      = cur_st;
    we          = 1'b0;
    enter_armed = 1'b0;
    case (cur_st)
      ST_IDLE: begin
        if (arm) begin
          nxt_st      = ST_ARMED;
          enter_armed = 1'b1;
        end
      end
      ST_ARMED: begin
        if (accept && prev_ok && trig_hit) begin
          we     = 1'b1;
          nxt_st = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (accept) begin
          we = 1'b1;
          if (wr_addr == LAST_ADDR) nxt_st = ST_READY;
        end
      end
      ST_READY: begin
        if (tick) nxt_st = ST_SWAP;
      end
      ST_SWAP: begin
        enter_armed = auto_rearm;
        nxt_st      = auto_rearm ? ST_ARMED : ST_IDLE;
      end
      default: nxt_st = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_st <= ST_IDLE;
    else        cur_st <= nxt_st;
  end

  // Write address: restarts at each arming, advances on every stored sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           wr_addr <= '0;
    else if (enter_armed) wr_addr <= '0;
    else if (we)          wr_addr <= wr_addr + ADDR_W'(1);
  end

  // Decimation down-counter; only moves on valid samples while capturing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  dcnt <= '0;
    else if (enter_armed)        dcnt <= decim;
    else if (live && sample_valid) begin
      if (dcnt == '0) dcnt <= decim;
      else            dcnt <= dcnt - DECIM_W'(1);
    end
  end

  // Previous accepted sample for the crossing test; invalid until the first accept after arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= '0;
      prev_ok <= 1'b0;
    end else if (enter_armed) begin
      prev_ok <= 1'b0;
    end else if (accept) begin
      prev    <= sample;
      prev_ok <= 1'b1;
    end
  end

  // Bank flip and frame counter update on the edge leaving SWAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_bank  <= 1'b0;
      frame_count <= '0;
    end else if (cur_st == ST_SWAP) begin
      front_bank  <= ~front_bank;
      frame_count <= frame_count + 16'd1;
    end
  end

  sample_ram #(
    .DATA_W (SAMPLE_W),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr ({~front_bank, wr_addr}),
    .wdata (sample),
    .raddr ({front_bank, rd_addr}),
    .rdata (rd_sample)
  );

endmodule

// File: tb/tb_scope_capture_ctrl.sv
module tb_scope_capture_ctrl;

  localparam int SW = 12;
  localparam int HD = 640;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_valid;
  logic [SW-1:0] sample;
  logic [SW-1:0] trig_level;
  logic          trig_rising;
  logic          auto_rearm;
  logic          arm;
  logic [DW-1:0] decim;
  logic [9:0]    h;
  logic [9:0]    v;
  logic [SW-1:0] rd_sample;
  logic          front_bank;
  logic [2:0]    state;
  logic [15:0]   frame_count;

  scope_capture_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .trig_level   (trig_level),
    .trig_rising  (trig_rising),
    .auto_rearm   (auto_rearm),
    .arm          (arm),
    .decim        (decim),
    .h            (h),
    .v            (v),
    .rd_sample    (rd_sample),
    .front_bank   (front_bank),
    .state        (state),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int gen_idx = 0;
  int cur_decim = 0;
  logic        exp_front = 1'b0;
  logic [15:0] exp_frames = '0;

  // Everything presented as a valid sample since the last arming, with the trigger settings of that cycle.
  logic [SW-1:0] fed_v[$];
  logic [SW-1:0] fed_l[$];
  logic          fed_r[$];
  logic [SW-1:0] exp_frame [HD];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic logic [SW-1:0] gen(input int mode, input int idx);
    case (mode)
      0:       return SW'(12'h7F0 + 8 * idx);
      1:       return SW'(idx);
      default: return SW'($urandom);
    endcase
  endfunction

  task automatic clear_model();
    fed_v.delete();
    fed_l.delete();
    fed_r.delete();
    gen_idx = 0;
  endtask

  task automatic feed(input logic [SW-1:0] s);
    sample       = s;
    sample_valid = 1'b1;
    fed_v.push_back(s);
    fed_l.push_back(trig_level);
    fed_r.push_back(trig_rising);
    step();
    sample_valid = 1'b0;
  endtask

  task automatic arm_now(input int d, input logic r, input logic [SW-1:0] lvl);
    decim       = DW'(d);
    cur_decim   = d;
    trig_rising = r;
    trig_level  = lvl;
    arm         = 1'b1;
    step();
    arm         = 1'b0;
    clear_model();
  endtask

  // Reference: keep every (d+1)-th valid sample, find the first crossing between
  // consecutive kept samples, and the screen is the next HD kept samples from there.
  task automatic build_expect(input string name);
    logic [SW-1:0] acc[$];
    logic [SW-1:0] accl[$];
    logic          accr[$];
    int t;
    for (int i = 0; i < fed_v.size(); i++) begin
      if ((i + 1) % (cur_decim + 1) == 0) begin
        acc.push_back(fed_v[i]);
        accl.push_back(fed_l[i]);
        accr.push_back(fed_r[i]);
      end
    end
    t = -1;
    for (int k = 1; k < acc.size() && t < 0; k++) begin
      if (accr[k]) begin
        if (acc[k-1] < accl[k] && acc[k] >= accl[k]) t = k;
      end else begin
        if (acc[k-1] > accl[k] && acc[k] <= accl[k]) t = k;
      end
    end
    n_cmp++;
    if (t < 0 || acc.size() < t + HD) begin
      n_err++;
      $display("FAIL %s model: DUT reached READY but stream holds trigger=%0d kept=%0d", name, t, acc.size());
      for (int j = 0; j < HD; j++) exp_frame[j] = 'x;
    end else begin
      for (int j = 0; j < HD; j++) exp_frame[j] = acc[t + j];
    end
  endtask

  task automatic capture_until(input int mode, input bit gaps, input logic [2:0] target, input string name);
    int budget = 20000;
    while (state !== target && budget > 0) begin
      if (gaps && $urandom_range(3) == 0) begin
        sample = SW'($urandom);
        step();
      end else begin
        if (mode == 2 && $urandom_range(15) == 0) trig_level  = SW'($urandom);
        if (mode == 2 && $urandom_range(31) == 0) trig_rising = 1'($urandom);
        feed(gen(mode, gen_idx));
        gen_idx++;
      end
      budget--;
    end
    chk({name, " reach state"}, state, target);
  endtask

  task automatic do_swap(input logic rearm, input string name);
    auto_rearm = rearm;
    chk({name, " pre-swap state"}, state, 3);
    h = 10'd0;
    v = 10'd480;
    step();
    chk({name, " swap state"}, state, 4);
    chk({name, " bank held in swap"}, front_bank, exp_front);
    h = 10'd1;
    v = 10'd0;
    step();
    exp_front  = ~exp_front;
    exp_frames = exp_frames + 16'd1;
    chk({name, " front_bank"}, front_bank, exp_front);
    chk({name, " frame_count"}, frame_count, exp_frames);
    chk({name, " post-swap state"}, state, rearm ? 1 : 0);
  endtask

  task automatic readback(input string name);
    for (int c = 0; c < HD; c++) begin
      h = 10'(c);
      step();
      n_cmp++;
      if (rd_sample !== exp_frame[c]) begin
        n_err++;
        $display("FAIL %s col %0d: got 0x%0h want 0x%0h", name, c, rd_sample, exp_frame[c]);
      end
    end
    h = 10'd700;
    step();
    chk({name, " h beyond display reads col 0"}, rd_sample, exp_frame[0]);
    h = 10'd1;
  endtask

  task automatic read_col(input int c, input logic [SW-1:0] req, input string name);
    h = 10'(c);
    step();
    chk(name, rd_sample, req);
    h = 10'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    chk("reset state", state, 0);
    chk("reset front_bank", front_bank, 0);
    chk("reset frame_count", frame_count, 0);
    chk("reset rd_sample", rd_sample, 0);
    rst_n = 1'b1;
    step();
    chk("idle after reset", state, 0);
  endtask

  task automatic test_rising();
    arm_now(0, 1'b1, 12'h800);
    chk("rising armed", state, 1);
    capture_until(0, 1'b0, 3'd3, "rising");
    build_expect("rising");
    do_swap(1'b0, "rising");
    readback("rising");
    read_col(0, 12'h800, "rising first write");
    read_col(5, exp_frame[5], "rising col5 one-cycle read");
  endtask

  task automatic test_decim();
    arm_now(3, 1'b1, 12'h010);
    capture_until(1, 1'b1, 3'd3, "decim");
    build_expect("decim");
    do_swap(1'b0, "decim");
    readback("decim");
    read_col(0, 12'd19, "decim trigger index");
    read_col(1, 12'd23, "decim addr1");
    read_col(2, 12'd27, "decim addr2");
  endtask

  task automatic test_falling();
    arm_now(0, 1'b0, 12'h800);
    for (int i = 0; i < 200; i++) feed(12'h900);
    chk("falling held armed", state, 1);
    feed(12'h7FF);
    chk("falling fired", state, 2);
    capture_until(2, 1'b0, 3'd3, "falling");
    build_expect("falling");
    do_swap(1'b1, "falling");
    read_col(0, 12'h7FF, "falling first write");
    readback("falling");
  endtask

  task automatic test_reset_mid_capture();
    // Auto re-arm left the FSM in ARMED with decim 0.
    clear_model();
    cur_decim   = 0;
    trig_rising = 1'b1;
    trig_level  = 12'h800;
    capture_until(0, 1'b0, 3'd2, "midreset");
    for (int i = 0; i < 299; i++) feed(gen(0, gen_idx + i));
    chk("midreset capturing", state, 2);
    rst_n = 1'b0;
    #2;
    chk("midreset state", state, 0);
    chk("midreset front_bank", front_bank, 0);
    chk("midreset frame_count", frame_count, 0);
    chk("midreset rd_sample", rd_sample, 0);
    step();
    rst_n      = 1'b1;
    exp_front  = 1'b0;
    exp_frames = '0;
    for (int i = 0; i < 10; i++) feed(SW'($urandom));
    chk("no capture without arm", state, 0);
  endtask

  task automatic test_tick_coincide();
    arm_now(0, 1'b1, 12'h800);
    capture_until(0, 1'b0, 3'd2, "coincide");
    for (int i = 0; i < 638; i++) begin
      feed(gen(0, gen_idx));
      gen_idx++;
    end
    chk("coincide still capturing", state, 2);
    h = 10'd0;
    v = 10'd480;
    feed(gen(0, gen_idx));
    h = 10'd1;
    v = 10'd0;
    chk("coincide tick ignored", state, 3);
    for (int i = 0; i < 20; i++) step();
    chk("coincide waits for next frame", state, 3);
    chk("coincide bank unchanged", front_bank, exp_front);
    build_expect("coincide");
    do_swap(1'b0, "coincide");
    readback("coincide");
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      arm_now($urandom_range(3), 1'($urandom), SW'($urandom_range(12'h300, 12'hC00)));
      capture_until(2, 1'b1, 3'd3, "random");
      build_expect("random");
      do_swap(1'b0, "random");
      readback("random");
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    trig_level   = '0;
    trig_rising  = 1'b1;
    auto_rearm   = 1'b0;
    arm          = 1'b0;
    decim        = '0;
    h            = 10'd1;
    v            = 10'd0;
    test_reset();
    test_rising();
    test_decim();
    test_falling();
    test_reset_mid_capture();
    test_tick_coincide();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
